// File: rtl/pattern_count_engine.sv
// Pattern counter: scans MSG_BYTES bytes from an external synchronous memory and counts PAT_W-bit pattern matches.
// Define PCE_STREAM_EN to build the history register and the cnt_stream (byte-crossing) counter.
module pattern_count_engine #(
  parameter int PAT_W     = 5,
  parameter int MSG_BYTES = 32,
  parameter int CNT_W     = 9
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req,
  input  logic [PAT_W-1:0]             pat,
  output logic [$clog2(MSG_BYTES)-1:0] mem_addr,
  input  logic [7:0]                   mem_rdata,
  output logic                         done,
  output logic [CNT_W-1:0]             cnt_within,
  output logic [CNT_W-1:0]             cnt_bytes,
  output logic [CNT_W-1:0]             cnt_stream
);

  localparam int AW = $clog2(MSG_BYTES);
  localparam int SW = $clog2(MSG_BYTES + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state, state_next;
  logic [PAT_W-1:0] pat_q;
  logic [SW-1:0]    step;
  logic             start, eval, last;
  logic [3:0]       within_n;

  // step counts RUN cycles; byte data from the memory trails the address by one, so step k holds byte k-1.
  assign start = (state == S_IDLE) && req;
  assign eval  = (state == S_RUN) && (step != '0);
  assign last  = (state == S_RUN) && (step == SW'(MSG_BYTES));
  assign done  = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (req)  state_next = S_RUN;
      S_RUN:   if (last) state_next = S_DONE;
      S_DONE:  if (!req) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    within_n = '0;
    for (int i = 0; i <= 8 - PAT_W; i++)
      if (mem_rdata[i +: PAT_W] == pat_q) within_n = within_n + 4'd1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pat_q      <= '0;
      mem_addr   <= '0;
      step       <= '0;
      cnt_within <= '0;
      cnt_bytes  <= '0;
    end else if (start) begin
      pat_q      <= pat;
      mem_addr   <= '0;
      step       <= '0;
      cnt_within <= '0;
      cnt_bytes  <= '0;
    end else if (state == S_RUN) begin
      if (!last) step <= step + 1'b1;
      if (mem_addr != AW'(MSG_BYTES - 1)) mem_addr <= mem_addr + 1'b1;
      if (eval) begin
        cnt_within <= cnt_within + CNT_W'(within_n);
        if (within_n != '0) cnt_bytes <= cnt_bytes + 1'b1;
      end
    end
  end

`ifdef PCE_STREAM_EN
  localparam int HIST_W = (PAT_W > 1) ? PAT_W - 1 : 1;

  logic [HIST_W-1:0] hist;
  logic [HIST_W+7:0] joined;
  logic [3:0]        cross_n;
  logic [3:0]        stream_n;

  assign joined = {hist, mem_rdata};

  // Windows that straddle the previous byte; byte 0 has no predecessor, so they are skipped there.
  always_comb begin
    cross_n = '0;
    for (int j = 9 - PAT_W; j < 8; j++)
      if (joined[j +: PAT_W] == pat_q) cross_n = cross_n + 4'd1;
  end

  assign stream_n = (step == SW'(1)) ? within_n : within_n + cross_n;

  always_ff @(posedge clk) begin
    if (!reset || start) begin
      hist       <= '0;
      cnt_stream <= '0;
    end else if (eval) begin
      hist       <= mem_rdata[HIST_W-1:0];
      cnt_stream <= cnt_stream + CNT_W'(stream_n);
    end
  end
`else
  assign cnt_stream = '0;
`endif

endmodule

// File: tb/tb_pattern_count_engine.sv
// Randomized self-checking bench for pattern_count_engine against a bit-stream reference model.
// Expects cnt_stream from the model when PCE_STREAM_EN is defined, otherwise zero.
module tb_pattern_count_engine;

  localparam int PAT_W     = 5;
  localparam int MSG_BYTES = 32;
  localparam int CNT_W     = 9;
  localparam int AW        = $clog2(MSG_BYTES);
  localparam int NBITS     = MSG_BYTES * 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             req;
  logic [PAT_W-1:0] pat;
  logic [AW-1:0]    mem_addr;
  logic [7:0]       mem_rdata = 8'h00;
  logic             done;
  logic [CNT_W-1:0] cnt_within, cnt_bytes, cnt_stream;

  logic [7:0] mem [MSG_BYTES];

  int n_checks = 0;
  int n_errors = 0;

  pattern_count_engine #(.PAT_W(PAT_W), .MSG_BYTES(MSG_BYTES), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .pat        (pat),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .done       (done),
    .cnt_within (cnt_within),
    .cnt_bytes  (cnt_bytes),
    .cnt_stream (cnt_stream)
  );

  always #5 clk = ~clk;

  // Synchronous-read data memory: data for an address appears one cycle later.
  always @(posedge clk) mem_rdata <= mem[mem_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: flatten the message into a bit stream (byte 0 first, MSB first) and slide the pattern over it.
  function automatic void model(input logic [PAT_W-1:0] p, output int w, output int b, output int s);
    logic bits [NBITS];
    bit   hit  [MSG_BYTES];
    bit   match;
    w = 0; b = 0; s = 0;
    for (int k = 0; k < MSG_BYTES; k++) begin
      hit[k] = 0;
      for (int t = 0; t < 8; t++) bits[k*8 + t] = mem[k][7-t];
    end
    for (int st = 0; st <= NBITS - PAT_W; st++) begin
      match = 1;
      for (int t = 0; t < PAT_W; t++)
        if (bits[st + t] != p[PAT_W-1-t]) match = 0;
      if (match) begin
        s++;
        if (st / 8 == (st + PAT_W - 1) / 8) begin
          w++;
          hit[st / 8] = 1;
        end
      end
    end
    for (int k = 0; k < MSG_BYTES; k++) if (hit[k]) b++;
`ifndef PCE_STREAM_EN
    s = 0;
`endif
  endfunction

  task automatic run(input string name, input logic [PAT_W-1:0] p);
    int ew, eb, es;
    int edge_n = 0;
    model(p, ew, eb, es);
    req = 1'b1;
    pat = p;
    @(posedge clk); #1;
    check({name, "/addr_start"}, mem_addr, 0);
    check({name, "/cnt_clear"}, cnt_within, 0);
    for (int n = 1; n <= 100 && edge_n == 0; n++) begin
      @(posedge clk); #1;
      if (done) edge_n = n;
      else if (n < MSG_BYTES) begin
        req = 1'($urandom);
        pat = PAT_W'($urandom);
      end else req = 1'b1;
    end
    check({name, "/done_edge"}, edge_n, MSG_BYTES + 1);
    check({name, "/addr_hold"}, mem_addr, MSG_BYTES - 1);
    check({name, "/cnt_within"}, cnt_within, ew);
    check({name, "/cnt_bytes"}, cnt_bytes, eb);
    check({name, "/cnt_stream"}, cnt_stream, es);
    repeat (5) begin
      @(posedge clk); #1;
      check({name, "/done_hold"}, done, 1);
      check({name, "/within_hold"}, cnt_within, ew);
    end
    req = 1'b0;
    @(posedge clk); #1;
    check({name, "/done_drop"}, done, 0);
    check({name, "/bytes_idle"}, cnt_bytes, eb);
    check({name, "/stream_idle"}, cnt_stream, es);
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b0;
    req   = 1'b1;
    pat   = '1;
    for (int k = 0; k < MSG_BYTES; k++) mem[k] = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst/done", done, 0);
    check("rst/addr", mem_addr, 0);
    check("rst/within", cnt_within, 0);
    check("rst/bytes", cnt_bytes, 0);
    check("rst/stream", cnt_stream, 0);
    req   = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < MSG_BYTES; k++) mem[k] = 8'hFF;
    run("ones", 5'b11111);
    for (int k = 0; k < MSG_BYTES; k++) mem[k] = 8'h55;
    run("alt", 5'b10101);
    for (int k = 0; k < MSG_BYTES; k++) mem[k] = 8'h00;
    run("zeros", 5'b11111);
    mem[0] = 8'h07;
    mem[1] = 8'hC0;
    run("cross", 5'b11111);

    // Abort a run mid-way with reset, then confirm a clean follow-up run.
    for (int k = 0; k < MSG_BYTES; k++) mem[k] = 8'hFF;
    req = 1'b1;
    pat = 5'b11111;
    @(posedge clk); #1;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("abort/done", done, 0);
    check("abort/addr", mem_addr, 0);
    check("abort/within", cnt_within, 0);
    check("abort/bytes", cnt_bytes, 0);
    check("abort/stream", cnt_stream, 0);
    reset = 1'b1;
    req   = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < MSG_BYTES; k++) mem[k] = 8'h00;
    run("after_abort", 5'b11111);

    for (int r = 0; r < 8; r++) begin
      logic [7:0] a, b;
      a = 8'($urandom);
      b = 8'($urandom);
      for (int k = 0; k < MSG_BYTES; k++)
        mem[k] = (r < 4) ? (($urandom_range(0, 1) != 0) ? a : b) : 8'($urandom);
      run("random", PAT_W'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
